// File: rtl/evo_lut_if.sv
// Config / evaluate / sweep bus of the evolvable LUT array.
// Driven by the evolution controller (master), served by evo_lut_array (slave).
interface evo_lut_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
);
    localparam int TT_W  = 1 << N_IN;
    localparam int CH_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int FIT_W = $clog2(N_OUT * TT_W + 1);

    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_tgt;
    logic [CH_W-1:0]  cfg_chan;
    logic [TT_W-1:0]  cfg_data;
    logic             in_valid;
    logic [N_IN-1:0]  in_vec;
    logic             out_valid;
    logic [N_OUT-1:0] out_vec;
    logic             sweep_start;
    logic             sweep_busy;
    logic             sweep_done;
    logic [FIT_W-1:0] fitness;

    modport master (
        output cfg_valid, cfg_tgt, cfg_chan, cfg_data, in_valid, in_vec, sweep_start,
        input  cfg_ready, out_valid, out_vec, sweep_busy, sweep_done, fitness
    );
    modport slave (
        input  cfg_valid, cfg_tgt, cfg_chan, cfg_data, in_valid, in_vec, sweep_start,
        output cfg_ready, out_valid, out_vec, sweep_busy, sweep_done, fitness
    );
endinterface

// File: rtl/evo_lut_array.sv
// N_OUT programmable truth-table LUTs with registered evaluation and a
// fitness sweep that scores every candidate against its target table.
module evo_lut_array #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
) (
    input logic      clk,
    input logic      rst_n,
    evo_lut_if.slave bus
);
    localparam int TT_W  = 1 << N_IN;
    localparam int CH_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int FIT_W = $clog2(N_OUT * TT_W + 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t                       state_q;
    logic [N_OUT-1:0][TT_W-1:0]   cand_q, tgt_q;
    logic [N_IN-1:0]              idx_q;
    logic [FIT_W-1:0]             acc_q, fitness_q, hits;
    logic                         busy_q, done_q, out_valid_q;
    logic [N_OUT-1:0]             out_vec_q;
    logic                         cfg_fire, eval_fire;

    assign cfg_fire  = bus.cfg_valid && (state_q != SWEEP);
    assign eval_fire = bus.in_valid && (state_q != SWEEP);

    // Matching (channel, vector) pairs at the current sweep index
    always_comb begin
        hits = '0;
        for (int j = 0; j < N_OUT; j++)
            hits = hits + FIT_W'(cand_q[j][idx_q] == tgt_q[j][idx_q]);
    end

    // Out-of-range channels match no j and are silently dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= '0;
            tgt_q  <= '0;
        end else if (cfg_fire) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (bus.cfg_chan == CH_W'(j)) begin
                    if (bus.cfg_tgt) tgt_q[j]  <= bus.cfg_data;
                    else             cand_q[j] <= bus.cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
        end else begin
            out_valid_q <= eval_fire;
            if (eval_fire)
                for (int j = 0; j < N_OUT; j++)
                    out_vec_q[j] <= cand_q[j][bus.in_vec];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            fitness_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.sweep_start) begin
                        state_q <= SWEEP;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                SWEEP: begin
                    if (&idx_q) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        fitness_q <= acc_q + hits;
                        idx_q     <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        acc_q <= acc_q + hits;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready  = (state_q != SWEEP);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_vec    = out_vec_q;
    assign bus.sweep_busy = busy_q;
    assign bus.sweep_done = done_q;
    assign bus.fitness    = fitness_q;
endmodule

// File: tb/tb_evo_lut_array.sv
// Randomized and directed bench for evo_lut_array against a truth-table model.
module tb_evo_lut_array;
    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int TT_W  = 1 << N_IN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    evo_lut_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();
    evo_lut_array #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Small instance where an out-of-range channel code is representable
    evo_lut_if #(.N_IN(2), .N_OUT(3)) sbus ();
    evo_lut_array #(.N_IN(2), .N_OUT(3)) sdut (.clk(clk), .rst_n(rst_n), .bus(sbus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [TT_W-1:0] m_cand [N_OUT];
    logic [TT_W-1:0] m_tgt  [N_OUT];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_fit();
        int s = 0;
        for (int j = 0; j < N_OUT; j++)
            for (int k = 0; k < TT_W; k++)
                if (m_cand[j][k] == m_tgt[j][k]) s++;
        return s;
    endfunction

    function automatic logic [N_OUT-1:0] model_eval(input int v);
        logic [N_OUT-1:0] r;
        for (int j = 0; j < N_OUT; j++) r[j] = m_cand[j][v];
        return r;
    endfunction

    task automatic model_wr(input bit tgt, input int chan, input logic [TT_W-1:0] d);
        if (chan < N_OUT) begin
            if (tgt) m_tgt[chan] = d;
            else     m_cand[chan] = d;
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < N_OUT; j++) begin
            m_cand[j] = '0;
            m_tgt[j]  = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input bit tgt, input int chan, input logic [TT_W-1:0] d,
                          input bit with_eval, input int v);
        logic [N_OUT-1:0] exp_vec;
        exp_vec = model_eval(v);
        chk("cfg_ready_idle", bus.cfg_ready, 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_tgt   = tgt;
        bus.cfg_chan  = chan[1:0];
        bus.cfg_data  = d;
        bus.in_valid  = with_eval;
        bus.in_vec    = v[N_IN-1:0];
        tick();
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b0;
        model_wr(tgt, chan, d);
        if (with_eval) begin
            chk("wr_eval_valid", bus.out_valid, 1);
            chk("wr_eval_oldtable", bus.out_vec, exp_vec);
        end
    endtask

    task automatic eval(input int v);
        logic [N_OUT-1:0] exp_vec;
        exp_vec = model_eval(v);
        bus.in_valid = 1'b1;
        bus.in_vec   = v[N_IN-1:0];
        tick();
        bus.in_valid = 1'b0;
        chk("eval_valid", bus.out_valid, 1);
        chk("eval_vec", bus.out_vec, exp_vec);
        tick();
        chk("idle_valid_low", bus.out_valid, 0);
        chk("idle_vec_hold", bus.out_vec, exp_vec);
    endtask

    task automatic sweep(input bit wr, input bit tgt, input int chan, input logic [TT_W-1:0] d);
        int cnt = 0;
        int bad = 0;
        int exp_fit;
        bus.sweep_start = 1'b1;
        bus.cfg_valid   = wr;
        bus.cfg_tgt     = tgt;
        bus.cfg_chan    = chan[1:0];
        bus.cfg_data    = d;
        tick();
        bus.sweep_start = 1'b0;
        bus.cfg_valid   = 1'b0;
        if (wr) model_wr(tgt, chan, d);
        exp_fit = model_fit();
        while (bus.sweep_busy && cnt < TT_W + 4) begin
            bad += int'(bus.sweep_done) + int'(bus.out_valid) + int'(bus.cfg_ready);
            bus.in_valid = 1'($urandom);
            bus.in_vec   = N_IN'($urandom);
            cnt++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("sweep_flags", bad, 0);
        chk("busy_cycles", cnt, TT_W);
        chk("done_pulse", bus.sweep_done, 1);
        chk("fitness", bus.fitness, exp_fit);
        tick();
        chk("done_width", bus.sweep_done, 0);
        chk("busy_after", bus.sweep_busy, 0);
        chk("fitness_hold", bus.fitness, exp_fit);
    endtask

    initial begin
        #200000;
        chk("watchdog", 1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int cnt, bad, exp_fit;
        bus.cfg_valid = 0; bus.cfg_tgt = 0; bus.cfg_chan = '0; bus.cfg_data = '0;
        bus.in_valid = 0; bus.in_vec = '0; bus.sweep_start = 0;
        sbus.cfg_valid = 0; sbus.cfg_tgt = 0; sbus.cfg_chan = '0; sbus.cfg_data = '0;
        sbus.in_valid = 0; sbus.in_vec = '0; sbus.sweep_start = 0;
        model_clear();

        #12;
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_busy", bus.sweep_busy, 0);
        chk("rst_done", bus.sweep_done, 0);
        chk("rst_fitness", bus.fitness, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_vec", bus.out_vec, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Zero candidates vs zero targets
        sweep(0, 0, 0, '0);
        chk("fit_all_zero", bus.fitness, 64);

        cfg_wr(0, 1, 16'hEEEE, 0, 0);
        eval(1);
        chk("eval_or_0001", bus.out_vec, 4'b0010);
        eval(4);
        chk("eval_or_0100", bus.out_vec, 4'b0000);
        cfg_wr(0, 1, 16'h0000, 0, 0);

        cfg_wr(1, 0, 16'hFFFF, 0, 0);
        sweep(0, 0, 0, '0);
        chk("fit_tgt0_ones", bus.fitness, 48);
        cfg_wr(0, 0, 16'hFFFF, 0, 0);
        sweep(0, 0, 0, '0);
        chk("fit_cand0_ones", bus.fitness, 64);

        // Write held and restart attempted during SWEEP
        exp_fit = model_fit();
        bus.sweep_start = 1'b1;
        tick();
        bus.sweep_start = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_tgt = 1'b0; bus.cfg_chan = 2'd2; bus.cfg_data = 16'h1234;
        cnt = 0; bad = 0;
        while (bus.sweep_busy && cnt < TT_W + 4) begin
            bad += int'(bus.cfg_ready);
            cnt++;
            bus.sweep_start = (cnt == 5);
            tick();
        end
        bus.sweep_start = 1'b0;
        chk("held_ready_low", bad, 0);
        chk("held_busy_cycles", cnt, TT_W);
        chk("held_done", bus.sweep_done, 1);
        chk("held_ready_done", bus.cfg_ready, 1);
        chk("held_fitness", bus.fitness, exp_fit);
        tick();
        bus.cfg_valid = 1'b0;
        model_wr(0, 2, 16'h1234);
        chk("no_resweep", bus.sweep_busy, 0);
        tick();
        chk("no_resweep2", bus.sweep_busy, 0);
        eval(2);
        eval(4);
        eval(5);
        eval(12);

        // Async reset at sweep index 7
        bus.sweep_start = 1'b1;
        tick();
        bus.sweep_start = 1'b0;
        repeat (7) tick();
        chk("pre_rst_busy", bus.sweep_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.sweep_busy, 0);
        chk("midrst_fitness", bus.fitness, 0);
        chk("midrst_done", bus.sweep_done, 0);
        chk("midrst_ready", bus.cfg_ready, 1);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            bad += int'(bus.sweep_done) + int'(bus.sweep_busy);
        end
        chk("midrst_no_done", bad, 0);
        for (int v = 0; v < TT_W; v += 5) eval(v);

        // Same-cycle write and eval sees the old table
        cfg_wr(0, 3, 16'hA5A5, 0, 0);
        cfg_wr(0, 3, 16'h5A5A, 1, 0);
        eval(0);

        // Small instance: channel code 3 is out of range
        sbus.cfg_valid = 1; sbus.cfg_chan = 2'd0; sbus.cfg_data = 4'hA;
        tick();
        sbus.cfg_data = 4'h5; sbus.in_valid = 1; sbus.in_vec = 2'd1;
        tick();
        chk("s_wr_eval_old", sbus.out_vec, 3'b001);
        sbus.cfg_chan = 2'd3; sbus.cfg_data = 4'hF;
        tick();
        chk("s_eval_new", sbus.out_vec, 3'b000);
        sbus.cfg_tgt = 1; sbus.in_vec = 2'd3;
        tick();
        sbus.cfg_valid = 0; sbus.cfg_tgt = 0;
        chk("s_oor_eval3", sbus.out_vec, 3'b000);
        sbus.in_vec = 2'd0;
        tick();
        sbus.in_valid = 0;
        chk("s_oor_eval0", sbus.out_vec, 3'b001);
        sbus.sweep_start = 1;
        tick();
        sbus.sweep_start = 0;
        cnt = 0;
        while (sbus.sweep_busy && cnt < 10) begin cnt++; tick(); end
        chk("s_busy_cycles", cnt, 4);
        chk("s_done", sbus.sweep_done, 1);
        chk("s_oor_fitness", sbus.fitness, 10);

        // Random mix against the model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: cfg_wr(1'($urandom), $urandom_range(0, N_OUT-1), TT_W'($urandom), 0, 0);
                1: eval($urandom_range(0, TT_W-1));
                2: cfg_wr(0, $urandom_range(0, N_OUT-1), TT_W'($urandom), 1,
                          $urandom_range(0, TT_W-1));
                3: sweep(0, 0, 0, '0);
                default: sweep(1, 1'($urandom), $urandom_range(0, N_OUT-1), TT_W'($urandom));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
